// File: rtl/bus_pkg.sv
// Shared definitions for the bus_ram slice: FSM encoding, byte-lane select
// constants and the bus data width.
package bus_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/bus_ram_mem.sv
// Single-port word RAM with synchronous per-byte write and combinational read,
// so the controller can register the read word on the same edge it commits.
module bus_ram_mem
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_ram.sv
// Four-phase strobe/ack RAM with optional wait states. Define
// BUS_RAM_RANGE_ERR_EN to add err_o for addresses beyond the array.
module bus_ram
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [31:0]           adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [3:0]            sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o
`ifdef BUS_RAM_RANGE_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int         CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_t                  state;
    logic [3:0]              cnt;
    logic                    err_q;
    logic                    enter_ack;
    logic                    range_err;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    unused;

    assign word_idx = adr_i[ADDR_WIDTH+1:2];

`ifdef BUS_RAM_RANGE_ERR_EN
    assign range_err = |(adr_i >> (ADDR_WIDTH + 2));
    assign err_o     = err_q;
    assign unused    = ^adr_i[1:0];
`else
    assign range_err = 1'b0;
    assign unused    = ^{adr_i[1:0], err_q, adr_i >> (ADDR_WIDTH + 2)};
`endif

    assign enter_ack = stb_i && (((state == IDLE) && (WAIT_STATES == 0)) ||
                                 ((state == WAIT) && (cnt == 4'd0)));

    // The array is written only on the edge that enters ACK, which makes each access commit once.
    assign be = (enter_ack && we_i && !range_err) ? sel_i : 4'b0000;

    bus_ram_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .be    (be),
        .addr  (word_idx),
        .wdata (dat_i),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack_o <= 1'b0;
            err_q <= 1'b0;
            dat_o <= '0;
        end else if (enter_ack) begin
            state <= ACK;
            cnt   <= 4'd0;
            if (range_err) begin
                err_q <= 1'b1;
                dat_o <= '0;
            end else begin
                ack_o <= 1'b1;
                if (!we_i) begin
                    dat_o <= rdata;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (stb_i) begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (!stb_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    if (!stb_i) begin
                        state <= IDLE;
                        ack_o <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
